// File: rtl/guess_pkg.sv
// Shared types and sizing for the guess_judge bulls-and-cows judge.
package guess_pkg;

    localparam int unsigned NUM_DIGITS     = 4;
    localparam int unsigned MAX_GUESS      = 15;
    localparam int unsigned COMPARE_CYCLES = 16;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned GCNT_W         = 4;
    localparam int unsigned IDX_W          = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/digit_validator.sv
// Flags a guess holding a non-BCD digit or any repeated digit.
module digit_validator
    import guess_pkg::*;
(
    input  logic [DIGIT_W-1:0] d1,
    input  logic [DIGIT_W-1:0] d2,
    input  logic [DIGIT_W-1:0] d3,
    input  logic [DIGIT_W-1:0] d4,
    output logic               invalid
);

    logic range_bad;
    logic dup_bad;

    assign range_bad = (d1 > DIGIT_W'(9)) || (d2 > DIGIT_W'(9)) ||
                       (d3 > DIGIT_W'(9)) || (d4 > DIGIT_W'(9));
    assign dup_bad   = (d1 == d2) || (d1 == d3) || (d1 == d4) ||
                       (d2 == d3) || (d2 == d4) || (d3 == d4);
    assign invalid   = range_bad || dup_bad;

endmodule

// File: rtl/guess_judge.sv
// Judges a latched 4-digit guess against a secret, one digit pair per cycle,
// producing exact (A) and misplaced (B) counts plus game bookkeeping.
module guess_judge
    import guess_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                new_game,
    input  logic [DIGIT_W-1:0]  q1,
    input  logic [DIGIT_W-1:0]  q2,
    input  logic [DIGIT_W-1:0]  q3,
    input  logic [DIGIT_W-1:0]  q4,
    input  logic [DIGIT_W-1:0]  a1,
    input  logic [DIGIT_W-1:0]  a2,
    input  logic [DIGIT_W-1:0]  a3,
    input  logic [DIGIT_W-1:0]  a4,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    a_cnt,
    output logic [CNT_W-1:0]    b_cnt,
    output logic                invalid,
    output logic                win,
    output logic [GCNT_W-1:0]   guess_cnt
);

    state_t state, state_n;

    // Index 0 holds the leftmost digit
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sq;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sa;
    logic [IDX_W-1:0]                   idx;
    logic [CNT_W-1:0]                   acc_a;
    logic [CNT_W-1:0]                   acc_b;

    logic             invalid_c;
    logic             match_c;
    logic             same_pos_c;
    logic             last_c;
    logic [CNT_W-1:0] a_sum_c;
    logic [CNT_W-1:0] b_sum_c;

    digit_validator u_validator (
        .d1      (sa[0]),
        .d2      (sa[1]),
        .d3      (sa[2]),
        .d4      (sa[3]),
        .invalid (invalid_c)
    );

    // idx[3:2] selects the guess digit (outer), idx[1:0] the secret digit (inner)
    always_comb begin
        match_c    = (sa[idx[3:2]] == sq[idx[1:0]]);
        same_pos_c = (idx[3:2] == idx[1:0]);
        a_sum_c    = acc_a + CNT_W'(match_c && same_pos_c);
        b_sum_c    = acc_b + CNT_W'(match_c && !same_pos_c);
        last_c     = (idx == IDX_W'(COMPARE_CYCLES - 1));
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && !win) state_n = LATCH;
            LATCH:   state_n = invalid_c ? DONE : COMPARE;
            COMPARE: if (last_c) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // new_game aborts everything and drops a coincident start
        if (new_game) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq        <= '0;
            sa        <= '0;
            idx       <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_cnt     <= '0;
            b_cnt     <= '0;
            invalid   <= 1'b0;
            win       <= 1'b0;
            guess_cnt <= '0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state == DONE) && !new_game;
            if (new_game) begin
                a_cnt     <= '0;
                b_cnt     <= '0;
                invalid   <= 1'b0;
                win       <= 1'b0;
                guess_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (state_n == LATCH) begin
                            sq <= {q4, q3, q2, q1};
                            sa <= {a4, a3, a2, a1};
                        end
                    end
                    LATCH: begin
                        idx   <= '0;
                        acc_a <= '0;
                        acc_b <= '0;
                        if (invalid_c) begin
                            a_cnt   <= '0;
                            b_cnt   <= '0;
                            invalid <= 1'b1;
                        end
                    end
                    COMPARE: begin
                        idx   <= idx + IDX_W'(1);
                        acc_a <= a_sum_c;
                        acc_b <= b_sum_c;
                        if (last_c) begin
                            a_cnt   <= a_sum_c;
                            b_cnt   <= b_sum_c;
                            invalid <= 1'b0;
                            if (a_sum_c == CNT_W'(NUM_DIGITS)) win <= 1'b1;
                            if (guess_cnt < GCNT_W'(MAX_GUESS))
                                guess_cnt <= guess_cnt + GCNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_judge.sv
// Scoreboard bench for guess_judge: expectations are queued at start and
// compared when done pulses.
module tb_guess_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       new_game;
    logic [3:0] q1, q2, q3, q4, a1, a2, a3, a4;
    logic       busy, done, invalid, win;
    logic [2:0] a_cnt, b_cnt;
    logic [3:0] guess_cnt;

    guess_judge dut (
        .clk(clk), .rst(rst), .start(start), .new_game(new_game),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .busy(busy), .done(done), .a_cnt(a_cnt), .b_cnt(b_cnt),
        .invalid(invalid), .win(win), .guess_cnt(guess_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] res;   // {a_cnt, b_cnt, invalid, win, guess_cnt}
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         total  = 0;
    int         passed = 0;
    logic [3:0] m_gcnt = 4'd0;
    logic       m_win  = 1'b0;

    task automatic set_digits(input logic [15:0] qv, input logic [15:0] av);
        {q1, q2, q3, q4} = qv;
        {a1, a2, a3, a4} = av;
    endtask

    // Reference model: A = positional matches, B = guess digit found at any other secret position
    function automatic exp_t model(input logic [15:0] qv, input logic [15:0] av);
        exp_t       e;
        logic [3:0] qd[4];
        logic [3:0] ad[4];
        logic       bad = 1'b0;
        logic [2:0] ea  = 3'd0;
        logic [2:0] eb  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            qd[i] = qv[15-4*i -: 4];
            ad[i] = av[15-4*i -: 4];
        end
        for (int i = 0; i < 4; i++) begin
            if (ad[i] > 4'd9) bad = 1'b1;
            for (int j = i + 1; j < 4; j++) if (ad[i] == ad[j]) bad = 1'b1;
        end
        if (bad) begin
            e.res = {3'd0, 3'd0, 1'b1, m_win, m_gcnt};
            e.lat = 2;
        end else begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (ad[i] == qd[j]) begin
                        if (i == j) ea = ea + 3'd1;
                        else        eb = eb + 3'd1;
                    end
            m_gcnt = (m_gcnt == 4'd15) ? 4'd15 : m_gcnt + 4'd1;
            if (ea == 3'd4) m_win = 1'b1;
            e.res = {ea, eb, 1'b0, m_win, m_gcnt};
            e.lat = 18;
        end
        return e;
    endfunction

    // Drive one start with the given digits, then scramble inputs; returns after the sampling edge
    task automatic issue(input logic [15:0] qv, input logic [15:0] av);
        set_digits(qv, av);
        sb.push_back(model(qv, av));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        set_digits(16'hFFFF, 16'hEEEE);
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        m_gcnt = 4'd0;
        m_win  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; new_game = 1'b0;
        set_digits(16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, a_cnt, b_cnt, invalid, win, guess_cnt} !== 14'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, a_cnt, b_cnt, invalid, win, guess_cnt});
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_release busy/done=%b want=00", {busy, done});
        else passed++;
    endtask

    task automatic test_mixed();
        logic [15:0] qs[8] = '{16'h1234, 16'h1234, 16'h1234, 16'h1123,
                               16'h0789, 16'h1234, 16'h1234, 16'h1234};
        logic [15:0] as[8] = '{16'h4321, 16'h5678, 16'h1243, 16'h5178,
                               16'h9870, 16'h1123, 16'h123C, 16'hA123};
        exp_t e;
        int   lat;
        bit   to;
        for (int k = 0; k < 8; k++) begin
            issue(qs[k], as[k]);
            total++;
            if (busy !== 1'b1) $display("FAIL mixed_busy[%0d] got=%b want=1", k, busy);
            else passed++;
            wait_done(lat, to);
            e = sb.pop_front();
            total++;
            if (to || lat != e.lat) $display("FAIL mixed_latency[%0d] got=%0d timeout=%0d want=%0d", k, lat, to, e.lat);
            else passed++;
            total++;
            if ({a_cnt, b_cnt, invalid, win, guess_cnt} !== e.res)
                $display("FAIL mixed_result[%0d] got=%h want=%h", k,
                         {a_cnt, b_cnt, invalid, win, guess_cnt}, e.res);
            else passed++;
        end
    endtask

    task automatic test_win();
        exp_t e;
        int   lat;
        bit   to;
        issue(16'h1234, 16'h1234);
        wait_done(lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat) $display("FAIL win_latency got=%0d timeout=%0d want=%0d", lat, to, e.lat);
        else passed++;
        total++;
        if ({a_cnt, b_cnt, invalid, win, guess_cnt} !== e.res)
            $display("FAIL win_result got=%h want=%h", {a_cnt, b_cnt, invalid, win, guess_cnt}, e.res);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL win_busy_at_done got=%b want=0", busy);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) $display("FAIL done_single_cycle got=%b want=0", done);
        else passed++;
        // start after a win must be ignored
        set_digits(16'h1234, 16'h5678);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL win_ignore_busy got=%b want=0", busy);
        else passed++;
        wait_done(lat, to);
        total++;
        if (!to) $display("FAIL win_ignore_done got=done_after_%0d want=no_done", lat);
        else passed++;
        total++;
        if ({a_cnt, b_cnt, win} !== {3'd4, 3'd0, 1'b1})
            $display("FAIL win_hold got=%h want=%h", {a_cnt, b_cnt, win}, {3'd4, 3'd0, 1'b1});
        else passed++;
    endtask

    task automatic test_new_game();
        pulse_new_game();
        total++;
        if ({a_cnt, b_cnt, invalid, win, guess_cnt} !== 12'd0)
            $display("FAIL new_game_clear got=%h want=0", {a_cnt, b_cnt, invalid, win, guess_cnt});
        else passed++;
    endtask

    task automatic test_saturate();
        exp_t e;
        int   lat;
        bit   to;
        for (int k = 0; k < 17; k++) begin
            issue(16'h1234, (k % 2 == 0) ? 16'h5678 : 16'h2135);
            wait_done(lat, to);
            e = sb.pop_front();
            total++;
            if (to || {a_cnt, b_cnt, invalid, win, guess_cnt} !== e.res)
                $display("FAIL saturate[%0d] got=%h timeout=%0d want=%h", k,
                         {a_cnt, b_cnt, invalid, win, guess_cnt}, to, e.res);
            else passed++;
        end
        total++;
        if (guess_cnt !== 4'd15) $display("FAIL saturate_final got=%0d want=15", guess_cnt);
        else passed++;
        pulse_new_game();
        total++;
        if ({win, guess_cnt} !== 5'd0) $display("FAIL saturate_new_game got=%h want=0", {win, guess_cnt});
        else passed++;
    endtask

    task automatic test_abort_reset();
        exp_t e;
        int   lat;
        bit   to;
        issue(16'h1234, 16'h4321);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        m_gcnt = 4'd0;
        m_win  = 1'b0;
        #2;
        total++;
        if ({busy, done, a_cnt, b_cnt, invalid, win, guess_cnt} !== 14'd0)
            $display("FAIL abort_reset_outputs got=%h want=0",
                     {busy, done, a_cnt, b_cnt, invalid, win, guess_cnt});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done(lat, to);
        total++;
        if (!to) $display("FAIL abort_reset_done got=done_after_%0d want=no_done", lat);
        else passed++;
        issue(16'h1357, 16'h1375);
        wait_done(lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat || {a_cnt, b_cnt, invalid, win, guess_cnt} !== e.res)
            $display("FAIL after_reset got=%h lat=%0d timeout=%0d want=%h lat=%0d",
                     {a_cnt, b_cnt, invalid, win, guess_cnt}, lat, to, e.res, e.lat);
        else passed++;
    endtask

    task automatic test_new_game_start();
        int lat;
        bit to;
        set_digits(16'h1234, 16'h5678);
        new_game = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        start    = 1'b0;
        m_gcnt   = 4'd0;
        m_win    = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL ng_start_busy got=%b want=0", busy);
        else passed++;
        wait_done(lat, to);
        total++;
        if (!to) $display("FAIL ng_start_done got=done_after_%0d want=no_done", lat);
        else passed++;
        total++;
        if ({a_cnt, b_cnt, invalid, win, guess_cnt} !== 12'd0)
            $display("FAIL ng_start_state got=%h want=0", {a_cnt, b_cnt, invalid, win, guess_cnt});
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        // New start issued in the cycle done is high
        issue(16'h2468, 16'h8642);
        wait_done(lat, to);
        e = sb.pop_front();
        issue(16'h2468, 16'h2460);
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_accept got=%b want=1", busy);
        else passed++;
        wait_done(lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat || {a_cnt, b_cnt, invalid, win, guess_cnt} !== e.res)
            $display("FAIL b2b_result got=%h lat=%0d timeout=%0d want=%h lat=%0d",
                     {a_cnt, b_cnt, invalid, win, guess_cnt}, lat, to, e.res, e.lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_win();
        test_new_game();
        test_saturate();
        test_abort_reset();
        test_new_game_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
